// File: rtl/bus_arbiter_pkg.sv
// Shared state encodings and default limits for the round-robin bus arbiter.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  localparam int DEFAULT_MAX_HOLD = 8;

endpackage

// File: rtl/busdriver.sv
// Tri-state driver placing din on the shared bus while en is high.
module busdriver #(
  parameter int W = 4
) (
  input  logic         en,
  input  logic [W-1:0] din,
  inout  tri   [W-1:0] bus
);

  assign bus = en ? din : {W{1'bz}};

endmodule

// File: rtl/rr_pick.sv
// Combinational wrap-around priority scan: first requester at or after ptr wins.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             found,
  output logic [ID_W-1:0]  idx
);

  int pos;

  // Scan from the farthest offset down so the closest requester to ptr is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = (int'(ptr) + k) % N_REQ;
      if (req[pos]) begin
        found = 1'b1;
        idx   = ID_W'(pos);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner selection for a shared tri-state bus, with hold limit and
// a one-cycle all-off turnaround between owners.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             bus_busy,
  output logic [ID_W-1:0]  owner,
  output logic             timeout
);

  localparam int CNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic              busy_q, busy_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic              timeout_q, timeout_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  hold_q, hold_d;

  logic              found;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W-1:0]   next_ptr;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (found),
    .idx   (win_idx)
  );

  assign next_ptr = (owner_q == LAST_ID) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    owner_d   = owner_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    case (state_q)
      ST_GRANT: begin
        if (!req[owner_q] || (MAX_HOLD != 0 && hold_q >= HOLD_MAX)) begin
          // A still-requesting owner here has hit the limit and is preempted.
          timeout_d = req[owner_q];
          grant_d   = '0;
          busy_d    = 1'b1;
          ptr_d     = next_ptr;
          state_d   = ST_TURN;
        end else if (MAX_HOLD != 0) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        if (found) begin
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          owner_d = win_idx;
          hold_d  = CNT_W'(1);
          busy_d  = 1'b1;
          state_d = ST_GRANT;
        end else begin
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      owner_q   <= '0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      owner_q   <= owner_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
    end
  end

  assign grant    = grant_q;
  assign bus_busy = busy_q;
  assign owner    = owner_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench: arbiter with MAX_HOLD=8 driving a busdriver bank, plus a
// second arbiter with the hold limit disabled for the round-robin sequence.
module tb_bus_arbiter;

  localparam logic [15:0] DRV_DATA = {4'b1001, 4'b1111, 4'b0011, 4'b0101};

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req, req0;
  logic [3:0] grant, grant0;
  logic       bus_busy, bus_busy0;
  logic [1:0] owner, owner0;
  logic       timeout, timeout0;
  tri   [3:0] shared_bus;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(.N_REQ(4), .ID_W(2), .MAX_HOLD(8)) dut (
    .clk(clk), .reset(reset), .req(req), .grant(grant),
    .bus_busy(bus_busy), .owner(owner), .timeout(timeout)
  );

  bus_arbiter #(.N_REQ(4), .ID_W(2), .MAX_HOLD(0)) u_nolimit (
    .clk(clk), .reset(reset), .req(req0), .grant(grant0),
    .bus_busy(bus_busy0), .owner(owner0), .timeout(timeout0)
  );

  for (genvar i = 0; i < 4; i++) begin : g_drv
    busdriver #(.W(4)) u_drv (
      .en(grant[i]), .din(DRV_DATA[i*4 +: 4]), .bus(shared_bus)
    );
  end

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag, input logic [3:0] g, input logic busy,
                              input logic [1:0] own, input logic to);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".busy"}, 32'(bus_busy), 32'(busy));
    check({tag, ".owner"}, 32'(owner), 32'(own));
    check({tag, ".timeout"}, 32'(timeout), 32'(to));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // An undriven net reads as Z, or as 0 where the simulator has no Z state.
  function automatic logic bus_is_idle(input logic [3:0] b);
    return (b === 4'bzzzz) || (b === 4'b0000);
  endfunction

  logic [3:0] prev_grant, prev_req, prev_grant0;
  logic [1:0] prev_owner;
  int         run_len;

  // Cycle-by-cycle invariants on both arbiters and the shared bus.
  always @(negedge clk) begin
    if (reset) begin
      prev_grant  = '0;
      prev_grant0 = '0;
      prev_req    = '0;
      prev_owner  = '0;
      run_len     = 0;
    end else begin
      check("onehot", 32'($countones(grant) <= 1), 32'd1);
      check("onehot0", 32'($countones(grant0) <= 1), 32'd1);
      check("no_switch", 32'(prev_grant == 0 || grant == 0 || grant == prev_grant), 32'd1);
      check("no_switch0", 32'(prev_grant0 == 0 || grant0 == 0 || grant0 == prev_grant0), 32'd1);
      check("timeout_model", 32'(timeout),
            32'(prev_grant != 0 && prev_req[prev_owner] && run_len == 8));
      check("timeout0_low", 32'(timeout0), 32'd0);
      if (grant != 0 && grant == prev_grant) run_len = run_len + 1;
      else if (grant != 0) run_len = 1;
      else run_len = 0;
      check("hold_limit", 32'(run_len <= 8), 32'd1);
      if (grant != 0) check("bus_owner", 32'(shared_bus), 32'(DRV_DATA[owner*4 +: 4]));
      else check("bus_idle", 32'(bus_is_idle(shared_bus)), 32'd1);
      prev_grant  = grant;
      prev_grant0 = grant0;
      prev_req    = req;
      prev_owner  = owner;
    end
  end

  initial begin
    reset = 1'b1;
    req   = '0;
    req0  = '0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    tick();
    check_output("idle", 4'b0000, 1'b0, 2'd0, 1'b0);

    // Asynchronous reset with no requests
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_output("rst_idle", 4'b0000, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    tick();

    // Single request, release, turnaround, idle
    req = 4'b0100;
    tick();
    check_output("single", 4'b0100, 1'b1, 2'd2, 1'b0);
    tick();
    check_output("single_hold", 4'b0100, 1'b1, 2'd2, 1'b0);
    req = 4'b0000;
    tick();
    check_output("single_turn", 4'b0000, 1'b1, 2'd2, 1'b0);
    tick();
    check_output("single_idle", 4'b0000, 1'b0, 2'd2, 1'b0);

    // Round robin with no hold limit
    req0 = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("rr_first", 32'(grant0), 32'(4'b0001 << (k % 4)));
      check("rr_owner", 32'(owner0), 32'(k % 4));
      tick();
      tick();
      check("rr_third", 32'(grant0), 32'(4'b0001 << (k % 4)));
      req0 = 4'b1111 & ~(4'b0001 << (k % 4));
      tick();
      check("rr_turn", 32'(grant0), 32'd0);
      check("rr_turn_busy", 32'(bus_busy0), 32'd1);
      req0 = 4'b1111;
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      check("nolimit_hold", 32'(grant0), 32'(4'b0010));
      tick();
    end
    req0 = 4'b0000;
    tick();
    check("nolimit_release", 32'(grant0), 32'd0);

    // Hold limit with a sole requester: preempted then reissued
    req = 4'b0001;
    tick();
    for (int i = 1; i <= 8; i++) begin
      check_output("limit_hold", 4'b0001, 1'b1, 2'd0, 1'b0);
      tick();
    end
    check_output("limit_preempt", 4'b0000, 1'b1, 2'd0, 1'b1);
    tick();
    check_output("limit_regrant", 4'b0001, 1'b1, 2'd0, 1'b0);

    // Hold limit with a competitor: preempted owner loses the next round
    req = 4'b0011;
    for (int i = 2; i <= 8; i++) begin
      tick();
      check("limit2_hold", 32'(grant), 32'(4'b0001));
    end
    tick();
    check_output("limit2_preempt", 4'b0000, 1'b1, 2'd0, 1'b1);
    tick();
    check_output("limit2_next", 4'b0010, 1'b1, 2'd1, 1'b0);

    // Reset while requester 1 drives 0011: bus released immediately
    @(negedge clk);
    check("bus_0011", 32'(shared_bus), 32'(4'b0011));
    #2 reset = 1'b1;
    #1 check_output("rst_grant", 4'b0000, 1'b0, 2'd0, 1'b0);
    check("rst_bus_idle", 32'(bus_is_idle(shared_bus)), 32'd1);
    req = 4'b0000;
    @(negedge clk);
    #2 reset = 1'b0;
    tick();

    // Release in the same cycle the hold count reaches the limit
    req = 4'b0001;
    tick();
    for (int i = 2; i <= 8; i++) tick();
    check_output("edge_last", 4'b0001, 1'b1, 2'd0, 1'b0);
    req = 4'b0000;
    tick();
    check_output("edge_release", 4'b0000, 1'b1, 2'd0, 1'b0);
    tick();
    check_output("edge_idle", 4'b0000, 1'b0, 2'd0, 1'b0);

    // Requests arriving mid-grant wait; pointer resumes after the owner
    req = 4'b0010;
    tick();
    check_output("late_own", 4'b0010, 1'b1, 2'd1, 1'b0);
    req = 4'b0111;
    tick();
    check_output("late_ignored", 4'b0010, 1'b1, 2'd1, 1'b0);
    req = 4'b0101;
    tick();
    check_output("late_turn", 4'b0000, 1'b1, 2'd1, 1'b0);
    tick();
    check_output("late_ptr", 4'b0100, 1'b1, 2'd2, 1'b0);
    req = 4'b0000;
    tick();
    tick();
    check_output("final_idle", 4'b0000, 1'b0, 2'd2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
